// File: rtl/intmul_arbiter.sv
// intmul_arbiter
//   Round-robin arbiter that lets N_REQ requesters share one fixed-latency
//   integer multiplier (an intmul_standard instance with LAT pipeline stages).
//   Accepted operands are registered onto mul_a/mul_b. A {valid, index} tag
//   travels alongside the multiplier pipeline so that each product is returned
//   to its requester exactly LAT+1 cycles after acceptance.
//
//   Optional feature: define INTMUL_ARB_STATS_EN to add the saturating
//   counters stat_ops (accepted operations) and stat_busy (cycles with idle low).
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active low
//   en         in   issue enable; low blocks new grants, in-flight ops complete
//   req_valid  in   [N_REQ]          per-requester operation pending
//   req_a      in   [N_REQ*W_A]      packed operand A, requester i at slice i
//   req_b      in   [N_REQ*W_B]      packed operand B, requester i at slice i
//   req_ready  out  [N_REQ]          one-hot-or-zero grant
//   mul_a      out  [W_A]            registered operand A to the multiplier
//   mul_b      out  [W_B]            registered operand B to the multiplier
//   mul_c      in   [W_A+W_B]        multiplier product (LAT cycles after mul_a/mul_b)
//   resp_valid out  [N_REQ]          one-cycle pulse marking the product owner
//   resp_c     out  [W_A+W_B]        product, zero when no resp_valid bit is high
//   idle       out                   nothing in flight and nothing being accepted
//   stat_ops   out  [32]             (INTMUL_ARB_STATS_EN only)
//   stat_busy  out  [32]             (INTMUL_ARB_STATS_EN only)

module intmul_arbiter #(
   parameter int N_REQ = 4,
   parameter int W_A   = 64,
   parameter int W_B   = 64,
   parameter int LAT   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*W_A-1:0]   req_a,
   input  logic [N_REQ*W_B-1:0]   req_b,
   output logic [N_REQ-1:0]       req_ready,
   output logic [W_A-1:0]         mul_a,
   output logic [W_B-1:0]         mul_b,
   input  logic [W_A+W_B-1:0]     mul_c,
   output logic [N_REQ-1:0]       resp_valid,
   output logic [W_A+W_B-1:0]     resp_c,
   output logic                   idle
`ifdef INTMUL_ARB_STATS_EN
   ,
   output logic [31:0]            stat_ops,
   output logic [31:0]            stat_busy
`endif
);

   localparam int IDX_W = $clog2(N_REQ);

   // Handshake: requester i hands over its operands when req_valid[i] and
   // req_ready[i] are both high at a rising edge. req_ready is a function of
   // req_valid, en and the round-robin pointer only, so a requester may hold
   // req_valid until it sees req_ready; there is no backpressure on responses.

   logic [IDX_W-1:0]   ptr_q, ptr_d;          // index of the last granted requester
   logic [W_A-1:0]     mul_a_q, mul_a_d;
   logic [W_B-1:0]     mul_b_q, mul_b_d;
   logic [LAT:0]       tag_v_q, tag_v_d;
   logic [IDX_W-1:0]   tag_idx_q [0:LAT];
   logic [IDX_W-1:0]   tag_idx_d [0:LAT];

   logic               grant_found;
   logic [IDX_W-1:0]   grant_idx;
   logic               accept;

   // Round-robin search: first valid requester after the pointer, wrapping.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int off = 1; off <= N_REQ; off++) begin
         if (!grant_found && req_valid[(int'(ptr_q) + off) % N_REQ]) begin
            grant_found = 1'b1;
            grant_idx   = IDX_W'((int'(ptr_q) + off) % N_REQ);
         end
      end
   end

   // The grant always targets a valid requester, so a grant is an acceptance.
   // Gating with rst keeps req_ready low while reset is held.
   assign accept    = rst && en && grant_found;
   assign req_ready = accept ? (N_REQ'(1) << grant_idx) : '0;

   always_comb begin
      ptr_d   = ptr_q;
      mul_a_d = mul_a_q;
      mul_b_d = mul_b_q;
      if (accept) begin
         ptr_d   = grant_idx;
         mul_a_d = req_a[grant_idx*W_A +: W_A];
         mul_b_d = req_b[grant_idx*W_B +: W_B];
      end
   end

   // Tag pipeline: stage 0 lines up with mul_a/mul_b, stage LAT with mul_c.
   always_comb begin
      tag_v_d      = '0;
      tag_v_d[0]   = accept;
      tag_idx_d[0] = grant_idx;
      for (int i = 1; i <= LAT; i++) begin
         tag_v_d[i]   = tag_v_q[i-1];
         tag_idx_d[i] = tag_idx_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q   <= IDX_W'(N_REQ - 1);   // requester 0 is searched first
         mul_a_q <= '0;
         mul_b_q <= '0;
         tag_v_q <= '0;
         for (int i = 0; i <= LAT; i++) begin
            tag_idx_q[i] <= '0;
         end
      end else begin
         ptr_q   <= ptr_d;
         mul_a_q <= mul_a_d;
         mul_b_q <= mul_b_d;
         tag_v_q <= tag_v_d;
         for (int i = 0; i <= LAT; i++) begin
            tag_idx_q[i] <= tag_idx_d[i];
         end
      end
   end

   assign mul_a      = mul_a_q;
   assign mul_b      = mul_b_q;
   assign resp_valid = tag_v_q[LAT] ? (N_REQ'(1) << tag_idx_q[LAT]) : '0;
   assign resp_c     = tag_v_q[LAT] ? mul_c : '0;
   assign idle       = !((|tag_v_q) || accept);

`ifdef INTMUL_ARB_STATS_EN
   logic [31:0] stat_ops_q, stat_ops_d;
   logic [31:0] stat_busy_q, stat_busy_d;

   // Both counters saturate at all-ones instead of wrapping.
   always_comb begin
      stat_ops_d  = stat_ops_q;
      stat_busy_d = stat_busy_q;
      if (accept && (stat_ops_q != 32'hFFFF_FFFF)) begin
         stat_ops_d = stat_ops_q + 32'd1;
      end
      if (!idle && (stat_busy_q != 32'hFFFF_FFFF)) begin
         stat_busy_d = stat_busy_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_ops_q  <= '0;
         stat_busy_q <= '0;
      end else begin
         stat_ops_q  <= stat_ops_d;
         stat_busy_q <= stat_busy_d;
      end
   end

   assign stat_ops  = stat_ops_q;
   assign stat_busy = stat_busy_q;
`endif

endmodule

// File: tb/tb_intmul_arbiter.sv
// tb_intmul_arbiter
//   Bench for intmul_arbiter with N_REQ=4, W_A=W_B=64, LAT=4. An ideal
//   LAT-stage multiplier is modelled here to close the loop on mul_c. A
//   behavioural model (round-robin choice over a list of valid requesters plus
//   a queue of due responses) is compared with the DUT every cycle; directed
//   sections pin the model with hand-computed literals.

module tb_intmul_arbiter;

   localparam int N   = 4;
   localparam int WA  = 64;
   localparam int WB  = 64;
   localparam int LAT = 4;
   localparam int WC  = WA + WB;
   localparam int EW  = 32 + 4 + WC;   // {due cycle, requester, product}

   logic              clk;
   logic              rst;
   logic              en;
   logic [N-1:0]      req_valid;
   logic [N*WA-1:0]   req_a;
   logic [N*WB-1:0]   req_b;
   logic [N-1:0]      req_ready;
   logic [WA-1:0]     mul_a;
   logic [WB-1:0]     mul_b;
   logic [WC-1:0]     mul_c;
   logic [N-1:0]      resp_valid;
   logic [WC-1:0]     resp_c;
   logic              idle;
`ifdef INTMUL_ARB_STATS_EN
   logic [31:0]       stat_ops;
   logic [31:0]       stat_busy;
`endif

   intmul_arbiter #(.N_REQ(N), .W_A(WA), .W_B(WB), .LAT(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_c      (mul_c),
      .resp_valid (resp_valid),
      .resp_c     (resp_c),
      .idle       (idle)
`ifdef INTMUL_ARB_STATS_EN
      ,
      .stat_ops   (stat_ops),
      .stat_busy  (stat_busy)
`endif
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- ideal multiplier, LAT cycles ----------------
   logic [WC-1:0] mpipe [0:LAT-1];
   always @(posedge clk) begin
      mpipe[0] <= {{WB{1'b0}}, mul_a} * {{WA{1'b0}}, mul_b};
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
   end
   assign mul_c = mpipe[LAT-1];

   // ---------------- check bookkeeping ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural model + scoreboard ----------------
   logic [EW-1:0] exp_q[$];
   int            model_last = N - 1;
   logic [WA-1:0] held_a = '0;
   logic [WB-1:0] held_b = '0;
   int            cyc = 0;

   // Lowest-numbered valid requester above the last grant, otherwise the
   // lowest-numbered valid requester overall; -1 when none is valid.
   function automatic int pick(input logic [N-1:0] v, input int last);
      int best;
      best = -1;
      for (int i = N - 1; i > last; i--) if (v[i]) best = i;
      if (best < 0) for (int i = N - 1; i >= 0; i--) if (v[i]) best = i;
      return best;
   endfunction

   always @(negedge clk) begin
      int            g;
      logic [N-1:0]  exp_rdy;
      logic [N-1:0]  exp_rv;
      logic [WC-1:0] exp_rc;
      logic [EW-1:0] e;
      logic [WC-1:0] prod;
      bit            busy;
      #2;
      if (!rst) begin
         exp_q.delete();
         model_last = N - 1;
         held_a = '0;
         held_b = '0;
         chk("rst_ready", req_ready, 0);
         chk("rst_resp_valid", resp_valid, 0);
         chk("rst_resp_c", resp_c, 0);
         chk("rst_idle", idle, 1);
         chk("rst_mul_a", mul_a, 0);
         chk("rst_mul_b", mul_b, 0);
      end else begin
         g = en ? pick(req_valid, model_last) : -1;
         exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
         chk("ready", req_ready, exp_rdy);
         chk("mul_a", mul_a, held_a);
         chk("mul_b", mul_b, held_b);
         busy   = (exp_q.size() != 0);
         exp_rv = '0;
         exp_rc = '0;
         if (exp_q.size() != 0 && exp_q[0][EW-1 -: 32] == 32'(cyc)) begin
            e      = exp_q.pop_front();
            exp_rv = N'(1) << e[WC +: 4];
            exp_rc = e[WC-1:0];
         end
         chk("resp_valid", resp_valid, exp_rv);
         chk("resp_c", resp_c, exp_rc);
         chk("idle", idle, !(busy || g >= 0));
         if (g >= 0) begin
            held_a = req_a[g*WA +: WA];
            held_b = req_b[g*WB +: WB];
            prod   = {{WB{1'b0}}, held_a} * {{WA{1'b0}}, held_b};
            exp_q.push_back({32'(cyc + LAT + 1), 4'(g), prod});
            model_last = g;
         end
      end
      cyc++;
   end

   // ---------------- driver tasks ----------------
   task automatic rand_ops();
      for (int i = 0; i < N; i++) begin
         req_a[i*WA +: WA] = {$urandom, $urandom};
         req_b[i*WB +: WB] = {$urandom, $urandom};
      end
   endtask

   task automatic step(input logic [N-1:0] v, input logic e);
      @(negedge clk);
      rand_ops();
      req_valid = v;
      en        = e;
   endtask

   task automatic pulse_reset(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         rst = 1'b0;
         req_valid = '0;
         en = 1'b0;
         #3;
         chk("pr_idle", idle, 1);
         chk("pr_resp_valid", resp_valid, 0);
      end
      @(negedge clk);
      rst = 1'b1;
      en  = 1'b1;
   endtask

   task automatic wait_idle(input int budget);
      for (int k = 0; k < budget; k++) begin
         step('0, 1'b1);
         #3;
         if (idle) break;
      end
      chk("idle_timeout", idle, 1);
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      logic [N-1:0] exp_g;
      int           pulses;
      rst = 1'b0;
      en = 1'b0;
      req_valid = '0;
      req_a = '0;
      req_b = '0;

      // Reset state
      repeat (2) @(negedge clk);
      #3;
      chk("t1_ready", req_ready, 0);
      chk("t1_idle", idle, 1);
      chk("t1_mul_a", mul_a, 0);
      chk("t1_resp_valid", resp_valid, 0);
      @(negedge clk);
      rst = 1'b1;

      // Single request from requester 2: 3*5 returns 5 cycles later
      step(4'b0100, 1'b1);
      req_a[2*WA +: WA] = 64'd3;
      req_b[2*WB +: WB] = 64'd5;
      #3;
      chk("t2_grant", req_ready, 4'b0100);
      for (int k = 1; k <= 4; k++) begin
         step('0, 1'b1);
         #3;
         chk("t2_quiet", resp_valid, 0);
      end
      step('0, 1'b1);
      #3;
      chk("t2_resp_valid", resp_valid, 4'b0100);
      chk("t2_resp_c", resp_c, 15);
      chk("t2_busy", idle, 0);
      step('0, 1'b1);
      #3;
      chk("t2_after", resp_valid, 0);
      chk("t2_idle", idle, 1);

      // Full-width product
      step(4'b0010, 1'b1);
      req_a[1*WA +: WA] = '1;
      req_b[1*WB +: WB] = '1;
      #3;
      chk("t3_grant", req_ready, 4'b0010);
      repeat (5) step('0, 1'b1);
      #3;
      chk("t3_resp_valid", resp_valid, 4'b0010);
      chk("t3_resp_c", resp_c, 128'hFFFFFFFFFFFFFFFE0000000000000001);

      // All requesters valid: grants 0,1,2,3,0,...
      pulse_reset(1);
      for (int k = 0; k < 12; k++) begin
         step(4'b1111, 1'b1);
         #3;
         exp_g = 4'b0001 << (k % 4);
         chk("t4_order", req_ready, exp_g);
      end
      wait_idle(20);

      // Two grants, then en dropped
      pulse_reset(1);
      step(4'b1111, 1'b1);
      #3;
      chk("t5_g0", req_ready, 4'b0001);
      step(4'b1111, 1'b1);
      #3;
      chk("t5_g1", req_ready, 4'b0010);
      for (int k = 2; k <= 7; k++) begin
         step(4'b1111, 1'b0);
         #3;
         chk("t5_blocked", req_ready, 0);
         if (k == 5) chk("t5_resp0", resp_valid, 4'b0001);
         if (k == 6) begin
            chk("t5_resp1", resp_valid, 4'b0010);
            chk("t5_busy", idle, 0);
         end
         if (k == 7) begin
            chk("t5_idle", idle, 1);
            chk("t5_quiet", resp_valid, 0);
         end
      end
      step(4'b1111, 1'b1);
      #3;
      chk("t5_resume", req_ready, 4'b0100);
      wait_idle(20);

      // Reset with three operations in flight
      pulse_reset(1);
      repeat (3) step(4'b1111, 1'b1);
      step('0, 1'b1);
      pulse_reset(2);
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         step('0, 1'b1);
         #3;
         if (resp_valid != 0) pulses++;
      end
      chk("t6_no_resp", pulses, 0);

      // Ten back-to-back operations from one requester
      pulse_reset(1);
      for (int k = 0; k < 10; k++) begin
         step(4'b0001, 1'b1);
         #3;
         chk("t7_grant", req_ready, 4'b0001);
      end
      wait_idle(20);
`ifdef INTMUL_ARB_STATS_EN
      chk("t7_stat_ops", stat_ops, 10);
      chk("t7_stat_busy", stat_busy, 10 + LAT + 1);
`endif

      // Random traffic with occasional resets
      for (int k = 0; k < 800; k++) begin
         step(4'($urandom_range(0, 15)), ($urandom_range(0, 7) != 0));
         if ($urandom_range(0, 199) == 0) pulse_reset(1);
      end
      wait_idle(30);

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
